suspend_ack_ctrl: RTL and testbench
===================================

# suspend_ack_ctrl

Fabric-side responder for the device suspend handshake. It receives the suspend request (SREQ) from the configuration logic, tells user logic to stop issuing new work, waits for in-flight activity to drain, then returns the acknowledge (SACK). It sits between the suspend primitive's SREQ/SACK pins and the user datapath, and implements a full four-phase request/acknowledge exchange with a drain timeout and a resume guard period.

## Interface
- SYNC_STAGES, 2: synchronizer flops on SREQ (legal range 2..4).
- DRAIN_CYCLES, 16: consecutive BUSY-low cycles required before acknowledging (≥1).
- TIMEOUT_CYCLES, 1024: maximum cycles spent in DRAIN before a forced acknowledge (> DRAIN_CYCLES).
- RESUME_CYCLES, 4: cycles QUIESCE stays high after SACK drops (≥1).

- CLK  in  1  sole clock; all logic on the rising edge.
- RST_N  in  1  reset, asynchronous assert and active-low; synchronous release is the integrator's responsibility.
- SREQ  in  1  suspend request from the suspend primitive; asynchronous to CLK.
- BUSY  in  1  user logic has in-flight transactions (synchronous to CLK).
- SACK  out  1  suspend acknowledge to the suspend primitive; registered.
- QUIESCE  out  1  instructs user logic to stop starting new transactions; registered.
- SUSPENDED  out  1  high while the acknowledge is held; registered.
- TIMEOUT  out  1  sticky flag: the last acknowledge was forced by the timeout; registered.

## Operation
- SREQ passes through a SYNC_STAGES flop chain; the last stage is `sreq_s`. No logic uses raw SREQ.
- FSM states and transitions:
  - IDLE: if `sreq_s` = 1, go to DRAIN and clear the quiet counter, timeout counter and TIMEOUT.
  - DRAIN:
    - Quiet counter: cleared when BUSY = 1, otherwise incremented.
    - Timeout counter: incremented every cycle.
    - Exit priority (highest first):
      - `sreq_s` = 0 → RESUME (request aborted; SACK never asserted).
      - BUSY = 0 and quiet count = DRAIN_CYCLES−1 → ACK.
      - Timeout count = TIMEOUT_CYCLES−1 → ACK and set TIMEOUT.
  - ACK: hold until `sreq_s` = 0, then go to RESUME.
  - RESUME: count RESUME_CYCLES, then go to IDLE. `sreq_s` is ignored here. A request re-raised during RESUME is taken from IDLE on the following cycle.
- Output decode (registered, reflecting the state entered):
  - QUIESCE = 1 in DRAIN, ACK and RESUME.
  - SACK = SUSPENDED = 1 in ACK only.
- TIMEOUT stays set until reset or the next entry into DRAIN.
- Counter widths are $clog2 of the relevant parameter (minimum 1 bit). Counters saturate and never wrap.
- Reset state: all outputs 0, FSM in IDLE, counters 0, synchronizer flops 0. Reset mid-handshake drops SACK and QUIESCE immediately, with no RESUME period.

## Timing
- SREQ rising before edge 0: `sreq_s` is high after SYNC_STAGES edges. DRAIN/QUIESCE are entered at the next edge E = SYNC_STAGES+1.
- With BUSY held low from E onward, SACK rises at edge E+DRAIN_CYCLES.
- With BUSY held high, SACK rises at E+TIMEOUT_CYCLES and TIMEOUT rises on the same edge.
- SREQ falling: SACK and SUSPENDED fall SYNC_STAGES+1 edges later. QUIESCE falls RESUME_CYCLES edges after that.
- SACK never rises unless `sreq_s` = 1 on the preceding edge. SACK never rises again until IDLE has been revisited.
- BUSY pulsing high in DRAIN restarts the quiet count and leaves the timeout count untouched.

## Test plan
- Defaults, BUSY = 0, SREQ raised at cycle 0 → QUIESCE at cycle 3, SACK/SUSPENDED at cycle 19. SREQ dropped at cycle 40 → SACK falls at 43, QUIESCE falls at 47.
- BUSY high for cycles 3..10, then low → SACK at cycle 11+16 = 27, TIMEOUT = 0.
- BUSY stuck high → SACK and TIMEOUT at cycle 3+1024 = 1027. The next request clears TIMEOUT on DRAIN entry.
- SREQ dropped at cycle 10, while in DRAIN → SACK never asserts, QUIESCE falls at cycle 17.
- SREQ re-raised during RESUME → FSM completes RESUME, returns to IDLE, re-enters DRAIN the next cycle, and acknowledges normally.
- RST_N pulsed low while in ACK → SACK, QUIESCE, SUSPENDED and TIMEOUT are 0 asynchronously. After release with SREQ held high, a full handshake repeats.

Source files
------------

// File: rtl/suspend_ack_ctrl.sv
// Suspend request/acknowledge responder: synchronizes SREQ, quiesces user logic,
// waits for BUSY to drain (or times out), then holds SACK until SREQ is withdrawn.
module suspend_ack_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int DRAIN_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RESUME_CYCLES  = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic SREQ,
    input  logic BUSY,
    output logic SACK,
    output logic QUIESCE,
    output logic SUSPENDED,
    output logic TIMEOUT
);

    localparam int QW = (DRAIN_CYCLES   > 1) ? $clog2(DRAIN_CYCLES)   : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (RESUME_CYCLES  > 1) ? $clog2(RESUME_CYCLES)  : 1;

    localparam logic [QW-1:0] QUIET_LAST   = QW'(DRAIN_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RESUME_LAST  = RW'(RESUME_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ACK,
        ST_RESUME
    } state_e;

    state_e            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              sreq_s;
    logic [QW-1:0]     quiet_q, quiet_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic              timeout_q, timeout_d;
    logic              sack_q, sack_d;
    logic              suspended_q, suspended_d;
    logic              quiesce_q, quiesce_d;

    // SREQ is asynchronous to CLK; only the last synchronizer stage is used.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SREQ};
        end
    end

    assign sreq_s = sync_q[SYNC_STAGES-1];

    // NOTE: every target gets a default first so this block cannot infer a latch.
    always_comb begin
        state_d   = state_q;
        quiet_d   = quiet_q;
        tcnt_d    = tcnt_q;
        rcnt_d    = rcnt_q;
        timeout_d = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sreq_s) begin
                    state_d   = ST_DRAIN;
                    quiet_d   = '0;
                    tcnt_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!sreq_s) begin
                    state_d = ST_RESUME;
                    rcnt_d  = '0;
                end else if (!BUSY && quiet_q == QUIET_LAST) begin
                    state_d = ST_ACK;
                end else if (tcnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_ACK;
                    timeout_d = 1'b1;
                end else begin
                    if (BUSY) begin
                        quiet_d = '0;
                    end else if (quiet_q != QUIET_LAST) begin
                        quiet_d = quiet_q + 1'b1;
                    end
                    if (tcnt_q != TIMEOUT_LAST) begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (!sreq_s) begin
                    state_d = ST_RESUME;
                    rcnt_d  = '0;
                end
            end
            ST_RESUME: begin
                // The request is deliberately ignored here; IDLE picks it up afterwards.
                if (rcnt_q == RESUME_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state being entered, then registered.
    always_comb begin
        quiesce_d   = (state_d != ST_IDLE);
        sack_d      = (state_d == ST_ACK);
        suspended_d = (state_d == ST_ACK);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            quiet_q     <= '0;
            tcnt_q      <= '0;
            rcnt_q      <= '0;
            timeout_q   <= 1'b0;
            sack_q      <= 1'b0;
            suspended_q <= 1'b0;
            quiesce_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            quiet_q     <= quiet_d;
            tcnt_q      <= tcnt_d;
            rcnt_q      <= rcnt_d;
            timeout_q   <= timeout_d;
            sack_q      <= sack_d;
            suspended_q <= suspended_d;
            quiesce_q   <= quiesce_d;
        end
    end

    assign SACK      = sack_q;
    assign SUSPENDED = suspended_q;
    assign QUIESCE   = quiesce_q;
    assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_suspend_ack_ctrl.sv
// Bench for suspend_ack_ctrl: a cycle reference model queues the expected outputs,
// a monitor pops and compares them; directed scenarios also check handshake latencies.
module tb_suspend_ack_ctrl;

    localparam int S = 2;
    localparam int D = 16;
    localparam int T = 1024;
    localparam int R = 4;

    logic CLK = 1'b0;
    logic RST_N;
    logic SREQ;
    logic BUSY;
    logic SACK, QUIESCE, SUSPENDED, TIMEOUT;

    int checks = 0;
    int errors = 0;

    suspend_ack_ctrl #(
        .SYNC_STAGES   (S),
        .DRAIN_CYCLES  (D),
        .TIMEOUT_CYCLES(T),
        .RESUME_CYCLES (R)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SREQ     (SREQ),
        .BUSY     (BUSY),
        .SACK     (SACK),
        .QUIESCE  (QUIESCE),
        .SUSPENDED(SUSPENDED),
        .TIMEOUT  (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Reference model: request history delayed by the synchronizer depth, then a
    // handshake phase with run-length counts of quiet cycles and elapsed drain time.
    localparam int PH_IDLE = 0, PH_DRAIN = 1, PH_HELD = 2, PH_RESUME = 3;

    logic     seen_q[$];
    logic [3:0] exp_q[$];
    int       m_phase;
    int       m_quiet_run;
    int       m_elapsed;
    int       m_resume_left;
    logic     m_timed_out;
    int       m_cycle = 0;

    always @(posedge CLK or negedge RST_N) begin
        logic seen;
        if (!RST_N) begin
            m_phase     = PH_IDLE;
            m_quiet_run = 0;
            m_elapsed   = 0;
            m_resume_left = 0;
            m_timed_out = 1'b0;
            seen_q.delete();
            for (int i = 0; i < S; i++) seen_q.push_back(1'b0);
            exp_q.delete();
        end else begin
            m_cycle++;
            seen = seen_q.pop_front();
            seen_q.push_back(SREQ);
            case (m_phase)
                PH_IDLE: if (seen) begin
                    m_phase     = PH_DRAIN;
                    m_quiet_run = 0;
                    m_elapsed   = 0;
                    m_timed_out = 1'b0;
                end
                PH_DRAIN: begin
                    if (!seen) begin
                        m_phase = PH_RESUME;
                        m_resume_left = R;
                    end else if (!BUSY && m_quiet_run + 1 >= D) begin
                        m_phase = PH_HELD;
                    end else if (m_elapsed + 1 >= T) begin
                        m_phase = PH_HELD;
                        m_timed_out = 1'b1;
                    end else begin
                        m_quiet_run = BUSY ? 0 : m_quiet_run + 1;
                        m_elapsed++;
                    end
                end
                PH_HELD: if (!seen) begin
                    m_phase = PH_RESUME;
                    m_resume_left = R;
                end
                default: begin
                    m_resume_left--;
                    if (m_resume_left == 0) m_phase = PH_IDLE;
                end
            endcase
            exp_q.push_back({m_phase == PH_HELD, m_phase != PH_IDLE,
                             m_phase == PH_HELD, m_timed_out});
        end
    end

    // Monitor: the DUT presents a registered output word every cycle.
    always @(negedge CLK) begin
        logic [3:0] exp_v;
        logic [3:0] act_v;
        if (RST_N && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {SACK, QUIESCE, SUSPENDED, TIMEOUT};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL scoreboard cycle %0d: got {sack,quiesce,susp,tmo}=%b expected %b",
                         m_cycle, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Waits for SACK (sel 0) or QUIESCE (sel 1) to reach val; checks the edge count.
    task automatic wait_for(input string name, input int sel, input logic val,
                            input int budget, input int exp_edges);
        int   n = 0;
        logic hit = 1'b0;
        while (!hit && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
            hit = ((sel == 0) ? SACK : QUIESCE) == val;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: got no event within %0d cycles expected after %0d",
                     name, budget, exp_edges);
        end else begin
            check(name, n, exp_edges);
        end
    endtask

    task automatic release_and_idle(input string name);
        SREQ = 1'b0;
        wait_for(name, 1, 1'b0, 40, S + 1 + R);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        SREQ  = 1'b0;
        BUSY  = 1'b0;
        repeat (3) @(posedge CLK);
        #3 RST_N = 1'b1;
        step(1);
        check("reset_sack", SACK, 0);
        check("reset_quiesce", QUIESCE, 0);
        check("reset_suspended", SUSPENDED, 0);
        check("reset_timeout", TIMEOUT, 0);

        // Basic handshake with BUSY low; request withdrawn at cycle 40.
        step(1);
        SREQ = 1'b1;
        wait_for("basic_quiesce_rise", 1, 1'b1, 20, S + 1);
        wait_for("basic_sack_rise", 0, 1'b1, 40, D);
        check("basic_suspended", SUSPENDED, 1);
        check("basic_timeout_clear", TIMEOUT, 0);
        step(40 - (S + 1 + D));
        SREQ = 1'b0;
        wait_for("basic_sack_fall", 0, 1'b0, 20, S + 1);
        check("basic_suspended_fall", SUSPENDED, 0);
        wait_for("basic_quiesce_fall", 1, 1'b0, 20, R);
        step(3);

        // BUSY high for cycles 3..10 restarts the quiet count: SACK at cycle 27.
        SREQ = 1'b1;
        step(S + 1);
        BUSY = 1'b1;
        step(8);
        BUSY = 1'b0;
        wait_for("busy_burst_sack", 0, 1'b1, 40, D);
        check("busy_burst_timeout", TIMEOUT, 0);
        release_and_idle("busy_burst_idle");
        step(3);

        // BUSY stuck high: forced acknowledge at cycle 3+1024.
        SREQ = 1'b1;
        BUSY = 1'b1;
        wait_for("timeout_sack", 0, 1'b1, T + 100, S + 1 + T);
        check("timeout_flag_set", TIMEOUT, 1);
        BUSY = 1'b0;
        release_and_idle("timeout_idle");
        check("timeout_flag_sticky", TIMEOUT, 1);
        step(2);
        SREQ = 1'b1;
        wait_for("timeout_next_drain", 1, 1'b1, 20, S + 1);
        check("timeout_cleared_on_drain", TIMEOUT, 0);
        wait_for("timeout_next_sack", 0, 1'b1, 40, D);
        release_and_idle("timeout_next_idle");
        step(3);

        // Request withdrawn at cycle 10 during DRAIN: QUIESCE falls at 17, no SACK.
        SREQ = 1'b1;
        BUSY = 1'b1;
        step(10);
        check("abort_no_sack", SACK, 0);
        SREQ = 1'b0;
        wait_for("abort_quiesce_fall", 1, 1'b0, 30, S + 1 + R);
        BUSY = 1'b0;
        step(3);

        // Request re-raised as soon as RESUME starts.
        SREQ = 1'b1;
        wait_for("rerase_first_sack", 0, 1'b1, 40, S + 1 + D);
        SREQ = 1'b0;
        wait_for("rerase_sack_fall", 0, 1'b0, 20, S + 1);
        SREQ = 1'b1;
        wait_for("rerase_resume_done", 1, 1'b0, 20, R);
        wait_for("rerase_drain_again", 1, 1'b1, 20, 1);
        wait_for("rerase_second_sack", 0, 1'b1, 40, D);
        release_and_idle("rerase_idle");
        step(3);

        // Reset pulse while acknowledged; handshake repeats with SREQ held high.
        SREQ = 1'b1;
        wait_for("rst_first_sack", 0, 1'b1, 40, S + 1 + D);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("rst_async_sack", SACK, 0);
        check("rst_async_quiesce", QUIESCE, 0);
        check("rst_async_suspended", SUSPENDED, 0);
        check("rst_async_timeout", TIMEOUT, 0);
        @(posedge CLK);
        #3 RST_N = 1'b1;
        wait_for("rst_repeat_sack", 0, 1'b1, 60, S + 1 + D);
        release_and_idle("rst_repeat_idle");
        step(3);

        // Randomized segments, checked by the scoreboard alone.
        for (int c = 0; c < 4200; c++) begin
            int seg;
            int busy_pct;
            int toggle_div;
            seg = c / 700;
            case (seg)
                0: begin busy_pct = 5;   toggle_div = 40;   end
                1: begin busy_pct = 40;  toggle_div = 80;   end
                2, 3: begin busy_pct = 100; toggle_div = 100000; end
                4: begin busy_pct = 70;  toggle_div = 25;   end
                default: begin busy_pct = 15; toggle_div = 8; end
            endcase
            @(posedge CLK);
            #1;
            if (c == 1400) SREQ = 1'b1;
            else if ($urandom_range(toggle_div - 1, 0) == 0) SREQ = ~SREQ;
            BUSY = ($urandom_range(99, 0) < busy_pct);
        end

        SREQ = 1'b0;
        BUSY = 1'b0;
        step(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
